// File: rtl/softmax_wb_if.sv
// Write-back bundle between the probability stage, the skid buffer and the output memory port.
interface softmax_wb_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          wb_ena;
  logic          wb_stall;
  logic [DW-1:0] proab_in;
  logic          mem_gnt;
  logic          mem_wr_ena;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          process_done;
  logic          overflow;

  modport master (
    output wb_ena, wb_stall, proab_in, mem_gnt,
    input  mem_wr_ena, mem_wr_addr, mem_wr_data, process_done, overflow
  );

  modport slave (
    input  wb_ena, wb_stall, proab_in, mem_gnt,
    output mem_wr_ena, mem_wr_addr, mem_wr_data, process_done, overflow
  );
endinterface

// File: rtl/softmax_wb.sv
// Softmax write-back: buffers probabilities in a skid FIFO and writes them to sequential addresses.
// Accept -> mem_wr_ena is 2 cycles minimum; mem_gnt=0 holds data, a push into a full FIFO with no pop is dropped.
module softmax_wb #(
  parameter int DATA_SIZE  = 1024,
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  softmax_wb_if.slave bus
);
  localparam int            PW        = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_SIZE - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_cnt;
  logic          r_armed;
  logic [AW-1:0] r_wcnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_wr_ena;
  logic          r_ovf;

  logic w_accept;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_last_wr;

  // r_armed keeps the cycle in which reset is released from accepting a sample
  assign w_accept  = r_armed & bus.wb_ena & ~bus.wb_stall;
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == FULL_CNT);
  assign w_pop     = ~w_empty & bus.mem_gnt;
  assign w_push    = w_accept & (~w_full | w_pop);
  assign w_drop    = w_accept & w_full & ~w_pop;
  assign w_last_wr = r_wr_ena & (r_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.proab_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed  <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_wcnt   <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_wr_ena <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_armed  <= 1'b1;
      r_wr_ena <= w_pop;
      r_cnt    <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_addr   <= r_wcnt;
        r_data   <= r_mem[r_rd_ptr];
        r_wcnt   <= (r_wcnt == LAST_ADDR) ? '0 : r_wcnt + 1'b1;
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // The write counter runs independently of the state, so a late last write still closes the iteration
  always_comb begin
    w_state_nxt = r_state;
    if (w_last_wr) begin
      w_state_nxt = S_DONE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
        S_RUN:   w_state_nxt = S_RUN;
        S_DONE:  w_state_nxt = (!w_empty || w_accept) ? S_RUN : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.mem_wr_ena   = r_wr_ena;
  assign bus.mem_wr_addr  = r_addr;
  assign bus.mem_wr_data  = r_data;
  assign bus.process_done = (r_state == S_DONE);
  assign bus.overflow     = r_ovf;
endmodule

// File: tb/tb_softmax_wb.sv
// Directed bench for softmax_wb with DATA_SIZE=4, FIFO_DEPTH=4.
module tb_softmax_wb;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  softmax_wb_if #(.AW(AW), .DW(DW)) bus();

  softmax_wb #(.DATA_SIZE(4), .AW(AW), .DW(DW), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic          ena;
    logic          stall;
    logic          gnt;
    logic [DW-1:0] din;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_done;
  } vec_t;

  vec_t          tbl[$];
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            n_done;
  int            n_cmp = 0;
  int            n_err = 0;

  function automatic vec_t mk(input int ena, input int stall, input int gnt, input int din,
                              input int e_wr, input int e_addr, input int e_data, input int e_done);
    vec_t v;
    v.ena    = ena[0];
    v.stall  = stall[0];
    v.gnt    = gnt[0];
    v.din    = DW'(din);
    v.e_wr   = e_wr[0];
    v.e_addr = AW'(e_addr);
    v.e_data = DW'(e_data);
    v.e_done = e_done[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int ena, input int stall, input int gnt, input int din);
    bus.wb_ena   = ena[0];
    bus.wb_stall = stall[0];
    bus.mem_gnt  = gnt[0];
    bus.proab_in = DW'(din);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.mem_wr_ena === 1'b1) begin
      wa_q.push_back(bus.mem_wr_addr);
      wd_q.push_back(bus.mem_wr_data);
    end
    if (bus.process_done === 1'b1) n_done++;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    n_done = 0;
  endtask

  task automatic chk_writes(input string nm, input int base, input int n);
    chk({nm, "_count"}, DW'(wa_q.size()), DW'(n));
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", nm, i), DW'(wa_q[i]), DW'(i % 4));
      chk($sformatf("%s_data%0d", nm, i), wd_q[i], DW'(base + i));
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_wr_ena"}, DW'(bus.mem_wr_ena), 0);
    chk({nm, "_addr"}, DW'(bus.mem_wr_addr), 0);
    chk({nm, "_data"}, bus.mem_wr_data, 0);
    chk({nm, "_done"}, DW'(bus.process_done), 0);
    chk({nm, "_ovf"}, DW'(bus.overflow), 0);
  endtask

  initial begin
    // basic stream, gnt always high
    tbl.push_back(mk(1,0,1,10, 0,0,0,0));
    tbl.push_back(mk(1,0,1,11, 1,0,10,0));
    tbl.push_back(mk(1,0,1,12, 1,1,11,0));
    tbl.push_back(mk(1,0,1,13, 1,2,12,0));
    tbl.push_back(mk(0,0,1,0,  1,3,13,0));
    tbl.push_back(mk(0,0,1,0,  0,0,0,1));
    tbl.push_back(mk(0,0,1,0,  0,0,0,0));
    // stall on the second sample
    tbl.push_back(mk(1,0,1,10, 0,0,0,0));
    tbl.push_back(mk(1,1,1,11, 1,0,10,0));
    tbl.push_back(mk(1,0,1,11, 0,0,0,0));
    tbl.push_back(mk(1,0,1,12, 1,1,11,0));
    tbl.push_back(mk(1,0,1,13, 1,2,12,0));
    tbl.push_back(mk(0,0,1,0,  1,3,13,0));
    tbl.push_back(mk(0,0,1,0,  0,0,0,1));
    tbl.push_back(mk(0,0,1,0,  0,0,0,0));
    // two back-to-back iterations
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1,0,1,i, (i > 0), (i + 3) % 4, i - 1, (i == 5)));
    tbl.push_back(mk(0,0,1,0,  1,3,7,0));
    tbl.push_back(mk(0,0,1,0,  0,0,0,1));
    tbl.push_back(mk(0,0,1,0,  0,0,0,0));
    // gnt toggling every cycle
    tbl.push_back(mk(1,0,0,20, 0,0,0,0));
    tbl.push_back(mk(1,0,1,21, 1,0,20,0));
    tbl.push_back(mk(1,0,0,22, 0,0,0,0));
    tbl.push_back(mk(1,0,1,23, 1,1,21,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,0));
    tbl.push_back(mk(0,0,1,0,  1,2,22,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,0));
    tbl.push_back(mk(0,0,1,0,  1,3,23,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,1));
    tbl.push_back(mk(0,0,1,0,  0,0,0,0));

    clear_log();
    drive(0,0,0,0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst = 1'b1;
    repeat (2) step();

    foreach (tbl[i]) begin
      drive(tbl[i].ena, tbl[i].stall, tbl[i].gnt, tbl[i].din);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wr_ena", i), DW'(bus.mem_wr_ena), DW'(tbl[i].e_wr));
      if (tbl[i].e_wr) begin
        chk($sformatf("v%0d_addr", i), DW'(bus.mem_wr_addr), DW'(tbl[i].e_addr));
        chk($sformatf("v%0d_data", i), bus.mem_wr_data, tbl[i].e_data);
      end
      chk($sformatf("v%0d_done", i), DW'(bus.process_done), DW'(tbl[i].e_done));
      chk($sformatf("v%0d_ovf", i), DW'(bus.overflow), 0);
    end

    // fill with gnt low, push+pop while full, then a dropped push
    clear_log();
    for (int i = 0; i < 4; i++) begin
      drive(1,0,0,30 + i);
      step();
    end
    chk("ovf_after_fill", DW'(bus.overflow), 0);
    drive(1,0,1,34);
    step();
    chk("ovf_full_with_pop", DW'(bus.overflow), 0);
    drive(1,0,0,35);
    step();
    chk("ovf_set", DW'(bus.overflow), 1);
    drive(0,0,1,0);
    repeat (8) step();
    chk("ovf_sticky", DW'(bus.overflow), 1);
    chk_writes("ovf_writes", 30, 5);
    chk("ovf_done_count", DW'(n_done), 1);

    rst = 1'b0;
    drive(0,0,0,0);
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();

    // reset after two of four writes
    clear_log();
    for (int i = 0; i < 3; i++) begin
      drive(1,0,1,40 + i);
      step();
    end
    chk_writes("pre_rst", 40, 2);
    rst = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    drive(0,0,0,0);
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    clear_log();
    for (int i = 0; i < 4; i++) begin
      drive(1,0,1,50 + i);
      step();
    end
    drive(0,0,1,0);
    repeat (6) step();
    chk_writes("post_rst", 50, 4);
    chk("post_rst_done_count", DW'(n_done), 1);
    chk("post_rst_ovf", DW'(bus.overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
